// File: rtl/fifo_rd_arbiter_if.sv
// Read-side bundle between the FIFO read controller, the arbiter and the
// downstream consumers. The master modport is the arbiter's view.
interface fifo_rd_arbiter_if #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4,
    parameter int IDW      = 2
);
    logic [NREQ-1:0]     req;
    logic                rempty;
    logic [DATASIZE-1:0] rdata;
    logic                rinc;
    logic [NREQ-1:0]     gnt;
    logic [DATASIZE-1:0] dout;
    logic                dout_valid;
    logic [IDW-1:0]      dout_id;

    modport master (
        input  req, rempty, rdata,
        output rinc, gnt, dout, dout_valid, dout_id
    );

    modport slave (
        output req, rempty, rdata,
        input  rinc, gnt, dout, dout_valid, dout_id
    );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin scheduler sharing the asynchronous FIFO's read port among NREQ
// consumers. One consumer holds the port for a burst of up to BURST pops; each
// popped word is registered and tagged with the owning consumer's index.
module fifo_rd_arbiter #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int BURST    = 4
) (
    input logic               rclk,
    input logic               rrst_n,
    fifo_rd_arbiter_if.master bus
);
    localparam int             CNTW     = $clog2(BURST) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t              state;
    logic [IDW-1:0]      cur;
    logic [IDW-1:0]      last;
    logic [CNTW-1:0]     cnt;
    logic [NREQ-1:0]     gnt_p0;
    logic                rinc_c;
    logic [IDW:0]        pick;
    logic                burst_done;

    logic [DATASIZE-1:0] dout_p1;
    logic                dout_valid_p1;
    logic [IDW-1:0]      dout_id_p1;

    // First requester found searching upward from after_idx+1 with wrap-around.
    // Returns {found, index}. Iterating from the far end downward lets the
    // nearest candidate overwrite any farther one.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  after_idx);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(after_idx) + i) % NREQ;
            if (r[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    assign pick       = rr_pick(bus.req, last);
    // Pop is combinational so a stalled FIFO resumes the same cycle it fills.
    assign rinc_c     = (state == S_BURST) && bus.req[cur] && !bus.rempty;
    assign burst_done = (rinc_c && (cnt == CNT_LAST)) || !bus.req[cur];

    // Arbitration FSM: IDLE -> ARB -> BURST, grant and pointers registered.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state  <= S_IDLE;
            cur    <= '0;
            last   <= IDW'(NREQ - 1);
            cnt    <= '0;
            gnt_p0 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if ((|bus.req) && !bus.rempty) state <= S_ARB;
                end
                S_ARB: begin
                    if (pick[IDW]) begin
                        cur    <= pick[IDW-1:0];
                        gnt_p0 <= {{(NREQ-1){1'b0}}, 1'b1} << pick[IDW-1:0];
                        cnt    <= '0;
                        state  <= S_BURST;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_BURST: begin
                    if (burst_done) begin
                        state  <= S_IDLE;
                        gnt_p0 <= '0;
                        last   <= cur;
                        cnt    <= '0;
                    end else if (rinc_c) begin
                        cnt    <= cnt + CNTW'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    gnt_p0 <= '0;
                end
            endcase
        end
    end

    // ---- stage p1: capture the popped word and its owner one cycle after the pop
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            dout_p1       <= '0;
            dout_valid_p1 <= 1'b0;
            dout_id_p1    <= '0;
        end else begin
            dout_valid_p1 <= rinc_c;
            if (rinc_c) begin
                dout_p1    <= bus.rdata;
                dout_id_p1 <= cur;
            end
        end
    end

    assign bus.rinc       = rinc_c;
    assign bus.gnt        = gnt_p0;
    assign bus.dout       = dout_p1;
    assign bus.dout_valid = dout_valid_p1;
    assign bus.dout_id    = dout_id_p1;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: a queue-based FIFO model feeds the arbiter, a
// transaction-level round-robin model predicts the owner of every written word,
// and a negedge monitor pops the scoreboard on each dout_valid.
module tb_fifo_rd_arbiter;
    localparam int DATASIZE = 8;
    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int BURST    = 4;

    typedef struct packed {
        logic [DATASIZE-1:0] data;
        logic [IDW-1:0]      id;
    } exp_t;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;

    fifo_rd_arbiter_if #(.DATASIZE(DATASIZE), .NREQ(NREQ), .IDW(IDW)) bus ();

    fifo_rd_arbiter #(.DATASIZE(DATASIZE), .NREQ(NREQ), .IDW(IDW), .BURST(BURST)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    always #5 rclk = ~rclk;

    logic [DATASIZE-1:0] fifo_q[$];
    exp_t                exp_q[$];
    int                  checks   = 0;
    int                  failures = 0;
    int                  received = 0;

    // Reference model state: who owns the port, words taken in the current
    // burst, who was served last, and the current request pattern.
    int              m_owner = -1;
    int              m_cnt   = 0;
    int              m_last  = NREQ - 1;
    logic [NREQ-1:0] m_req   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    function automatic int model_pick();
        for (int i = 1; i <= NREQ; i++) begin
            int c;
            c = (m_last + i) % NREQ;
            if (m_req[c]) return c;
        end
        return 0;
    endfunction

    // Owner of the next word to leave the FIFO.
    function automatic int model_take();
        int id;
        if (m_owner < 0) begin
            m_owner = model_pick();
            m_cnt   = 0;
        end
        id = m_owner;
        m_cnt++;
        if (m_cnt == BURST) begin
            m_last  = m_owner;
            m_owner = -1;
        end
        return id;
    endfunction

    task automatic refresh();
        bus.rempty = (fifo_q.size() == 0);
        bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic write_word(input logic [DATASIZE-1:0] d);
        exp_t e;
        e.data = d;
        e.id   = IDW'(model_take());
        fifo_q.push_back(d);
        exp_q.push_back(e);
        refresh();
    endtask

    task automatic set_req(input logic [NREQ-1:0] r);
        if (m_owner >= 0 && !r[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
        m_req   = r;
        bus.req = r;
    endtask

    task automatic slot();
        @(posedge rclk);
        #2;
    endtask

    // Wait for every written word to come out, then compare the settled grant.
    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
            @(posedge rclk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d_left required=0", name, exp_q.size());
        end
        repeat (3) @(posedge rclk);
        #2;
        check({name, "_gnt"}, 32'(bus.gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check({name, "_rinc"}, 32'(bus.rinc), 32'd0);
    endtask

    // FIFO model: pop on the edge where rinc was high, then present the new head.
    always @(posedge rclk) begin
        logic p;
        p = bus.rinc;
        #1;
        if (!rrst_n) fifo_q.delete();
        else if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh();
    end

    // Monitor: scoreboard pop on dout_valid plus per-cycle invariants.
    logic rinc_prev = 1'b0;
    always @(negedge rclk) begin
        exp_t e;
        if (!rrst_n) begin
            rinc_prev = 1'b0;
        end else begin
            check("latency", 32'(bus.dout_valid), 32'(rinc_prev));
            check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            if (bus.rinc) begin
                check("rinc_when_empty", 32'(bus.rempty), 32'd0);
                check("rinc_without_gnt", 32'(|bus.gnt), 32'd1);
            end
            if (bus.dout_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_dout actual=%0h required=none", bus.dout);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", 32'(bus.dout), 32'(e.data));
                    check("dout_id", 32'(bus.dout_id), 32'(e.id));
                    received++;
                end
            end
            rinc_prev = bus.rinc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bus.req    = '0;
        bus.rempty = 1'b1;
        bus.rdata  = '0;
        rrst_n     = 1'b0;

        repeat (3) begin
            @(negedge rclk);
            check("rst_rinc", 32'(bus.rinc), 32'd0);
            check("rst_gnt", 32'(bus.gnt), 32'd0);
            check("rst_dout", 32'(bus.dout), 32'd0);
            check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
            check("rst_dout_id", 32'(bus.dout_id), 32'd0);
        end
        slot();
        rrst_n = 1'b1;
        repeat (5) begin
            @(negedge rclk);
            check("idle_gnt", 32'(bus.gnt), 32'd0);
            check("idle_rinc", 32'(bus.rinc), 32'd0);
        end

        // Fairness: all request, grants rotate 0,1,2,3,0.
        slot();
        set_req(4'b1111);
        for (int i = 0; i < 20; i++) write_word(DATASIZE'(8'h40 + i));
        wait_quiet("rr");

        // Single consumer: 10 words, last burst of 2 then holds on empty.
        set_req(4'b0100);
        for (int i = 0; i < 10; i++) write_word(DATASIZE'(8'h10 + i));
        wait_quiet("full");

        // Empty stall: one word, grant holds, three more finish the burst.
        set_req(4'b0010);
        write_word(8'hA0);
        wait_quiet("stall1");
        slot();
        for (int i = 1; i < 4; i++) write_word(DATASIZE'(8'hA0 + i));
        wait_quiet("stall2");

        // Early release by consumer 3, then 0 must win over 3.
        set_req(4'b1000);
        write_word(8'hB0);
        write_word(8'hB1);
        wait_quiet("rel_hold");
        set_req(4'b0000);
        wait_quiet("rel_drop");
        set_req(4'b1001);
        for (int i = 0; i < 4; i++) write_word(DATASIZE'(8'hC0 + i));
        wait_quiet("rel_next");

        // Randomized request patterns and bursty writes.
        for (int r = 0; r < 15; r++) begin
            set_req(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
            n = $urandom_range(1, 3);
            for (int c = 0; c < n; c++) begin
                int k;
                k = $urandom_range(1, 7);
                for (int w = 0; w < k; w++) write_word(DATASIZE'($urandom));
                repeat ($urandom_range(0, 6)) slot();
            end
            wait_quiet("rand");
        end

        // Reset mid-burst after the second word of a grant.
        set_req(4'b0110);
        base = received;
        for (int i = 0; i < 8; i++) write_word(DATASIZE'(8'hD0 + i));
        n = 0;
        while (received < base + 2 && n < 100) begin
            @(negedge rclk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL midrst_wait actual=%0d required=%0d", received - base, 2);
        end
        @(posedge rclk);
        #1;
        rrst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = NREQ - 1;
        #1;
        check("midrst_rinc", 32'(bus.rinc), 32'd0);
        check("midrst_gnt", 32'(bus.gnt), 32'd0);
        check("midrst_dout_valid", 32'(bus.dout_valid), 32'd0);
        refresh();
        set_req(4'b1111);
        repeat (3) slot();
        rrst_n = 1'b1;
        slot();
        for (int i = 0; i < 4; i++) write_word(DATASIZE'(8'hE0 + i));
        wait_quiet("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
